// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3, one input bit per clock.
// Result and overflow flag are held until the next completed conversion.
module bin2bcd_seq #(
  parameter int IN_W = 16,
  parameter int NDIG = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [IN_W-1:0]      din,
  output logic                 busy,
  output logic                 done,
  output logic [4*NDIG-1:0]    bcd,
  output logic                 ovf
);

  localparam int AW = 4*NDIG + 4;
  localparam int CW = $clog2(IN_W + 1);
  localparam int unsigned LIMIT = 10**NDIG;

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t             state;
  logic [IN_W-1:0]    sh_bin;
  logic [AW-1:0]      acc;
  logic [AW-1:0]      acc_adj;
  logic [AW+IN_W-1:0] shifted;
  logic [CW-1:0]      cnt;
  logic               ovf_n;

  // Add 3 to every digit >= 5 so the following left shift carries correctly.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < NDIG + 1; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    shifted = {acc_adj, sh_bin} << 1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      sh_bin <= '0;
      acc    <= '0;
      cnt    <= '0;
      ovf_n  <= 1'b0;
      done   <= 1'b0;
      bcd    <= '0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_bin <= din;
            acc    <= '0;
            cnt    <= CW'(IN_W);
            ovf_n  <= (32'(din) >= LIMIT);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          {acc, sh_bin} <= shifted;
          cnt           <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= FIN;
          end
        end
        FIN: begin
          bcd   <= ovf_n ? {NDIG{4'hE}} : acc[4*NDIG-1:0];
          ovf   <= ovf_n;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
